n1_dsp_mul_arb: RTL and testbench
=================================

// Module: n1_dsp_mul_arb
// PURPOSE
//  Shares the DSP partition's single 16x16 multiplier between NREQ requesters (ALU plus coprocessor/extension ports).
//  Round-robin arbitration with an optional bounded lock for multi-op sequences such as double-precision products.
//  Registers the winning operands onto the alu2dsp_mul_* inputs and returns the 32-bit product after a fixed latency.
//  Each result carries a one-hot valid naming the requester that issued the operation.
// PARAMETERS
//  NREQ      2   number of requesters (2..4)
//  MUL_LAT   2   cycles from accept to res_vld_o (>=2: 1 operand stage + MUL_LAT-1 result stages)
//  LOCK_MAX  4   max consecutive locked grants before lock is ignored for one arbitration (1..15)
// PORTS
//  clk_i               in   1         module clock
//  async_rst_i         in   1         asynchronous reset, active-low
//  req_i               in   NREQ      operation request per requester
//  lock_i              in   NREQ      keep grant for next op (qualified by req_i)
//  sel_i               in   NREQ      1:signed, 0:unsigned per requester
//  opd0_i              in   NREQ*16   first operand, requester k at [16k+15:16k]
//  opd1_i              in   NREQ*16   second operand, same packing
//  gnt_o               out  NREQ      one-hot grant; accept = req_i[k] & gnt_o[k]
//  res_o               out  32        product of the op flagged by res_vld_o
//  res_vld_o           out  NREQ      one-hot result strobe, 1 cycle
//  arb2dsp_mul_sel_o   out  1         to DSP alu2dsp_mul_sel_i
//  arb2dsp_mul_opd0_o  out  16        to DSP alu2dsp_mul_opd0_i
//  arb2dsp_mul_opd1_o  out  16        to DSP alu2dsp_mul_opd1_i
//  dsp2arb_mul_res_i   in   32        from DSP dsp2alu_mul_res_o (combinational in DSP)
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: gnt_o=0, res_vld_o=0, res_o=0, arb2dsp_* =0, rr pointer=0, no lock owner, lock count=0, pipeline empty.
//  Grant is combinational from req_i and registered state; at most one bit set; gnt_o=0 when req_i=0.
//  Arbitration: when unlocked, first requesting index at or after ptr (wrapping) wins. After an accept by k, ptr<=(k+1)%NREQ.
//  Lock: accept with lock_i[k]=1 makes k owner; the next cycle only k may be granted while req_i[k]&lock_i[k] is asserted.
//   Other requests wait, no grant is issued to them.
//  Lock release: owner accepts with lock_i=0 (that op is still granted), or owner drops req_i (released that cycle; normal arbitration).
//  Lock bound: count increments per locked accept. On the LOCK_MAX-th consecutive one, lock is released and k is treated as unlocked.
//   If another requester waits it then wins via RR.
//  Accept at cycle t: opd0/opd1/sel of k are registered, driving arb2dsp_* in t+1.
//   dsp2arb_mul_res_i is sampled at end of t+1 and delayed MUL_LAT-2 further stages.
//   res_o is valid with res_vld_o[k]=1 in cycle t+MUL_LAT.
//  Throughput: one accept per cycle, back-to-back across requesters. Results emerge in accept order, no backpressure.
//  Idle cycles (no accept): arb2dsp_* hold their last value; res_o holds last result; res_vld_o=0.
//  Requester dropping req_i after accept: in-flight result is still delivered.
//  Reset mid-operation: all in-flight ops discarded; no res_vld_o after reset deassertion until a new accept.
//  Signed/unsigned handled entirely in the DSP; arbiter only forwards sel. No width conversion.
// STRUCTURE
//  Package n1_dsp_arb_pkg: OPD_W=16, RES_W=32, typedef pipe_tag_t {vld, id[$clog2(NREQ)]}, NREQ_MAX=4.
//  Sub-module n1_rr_arb: combinational RR grant from (req, ptr, lock_owner, lock_vld); reused by the other arbiters.
//  Top: operand register stage, tag shift register (MUL_LAT stages), result delay regs, lock FSM (UNLOCKED/LOCKED + count).
// TESTING
//  1. Reset, req_i=01, opd0=3, opd1=5, sel=0, MUL_LAT=2 -> gnt_o=01 at t, arb2dsp_opd0/opd1=3/5 at t+1; res_o=15, res_vld_o=01 at t+2.
//  2. req_i=11 held 4 cycles, no lock -> gnt_o 01,10,01,10; res_vld_o follows same sequence 2 cycles later.
//  3. Signed: sel=1, opd0=16'hFFFF, opd1=2 -> res_o=32'hFFFFFFFE; same operands with sel=0 -> 32'h0001FFFE.
//  4. req_i=11, lock_i=01 held, LOCK_MAX=4 -> gnt_o=01 x4, then 10 once, then 01 again.
//  5. Owner 0 drops req_i while locked, req_i[1]=1 -> gnt_o=10 same cycle; results for prior owner ops still delivered.
//  6. Accept at t, async_rst_i low at t+1 for 1 cycle -> res_vld_o stays 0; all outputs at reset values.

Source files
------------

// File: rtl/n1_dsp_arb_pkg.sv
// Shared types and constants for the DSP multiplier arbiter.
package n1_dsp_arb_pkg;

  localparam int unsigned OPD_W    = 16;
  localparam int unsigned RES_W    = 32;
  localparam int unsigned NREQ_MAX = 4;
  localparam int unsigned ID_W     = $clog2(NREQ_MAX);
  localparam int unsigned CNT_W    = 4;

  // One pipeline slot: valid flag plus the requester that issued the op.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } pipe_tag_t;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_st_e;

  // Requester index to one-hot strobe.
  function automatic logic [NREQ_MAX-1:0] id2onehot(input logic [ID_W-1:0] id);
    return NREQ_MAX'(1) << id;
  endfunction

endpackage

// File: rtl/n1_rr_arb.sv
// Combinational round-robin grant with an optional sticky owner.
//  req        : request vector
//  ptr        : first index considered when unlocked
//  lock_owner : index held while lock_vld and its request is up
//  lock_vld   : lock currently in force
//  gnt        : one-hot grant, zero when req is zero
module n1_rr_arb #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  input  logic [PTR_W-1:0] lock_owner,
  input  logic             lock_vld,
  output logic [NREQ-1:0]  gnt
);

  logic [PTR_W-1:0] idx_c;

  // Owner keeps the grant while it still requests; otherwise scan from ptr with wrap.
  always_comb begin
    gnt   = '0;
    idx_c = '0;
    if (lock_vld && req[lock_owner]) begin
      gnt[lock_owner] = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        idx_c = PTR_W'((32'(ptr) + i) % NREQ);
        if (req[idx_c] && (gnt == '0)) begin
          gnt[idx_c] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/n1_dsp_mul_arb.sv
// Shares the single DSP 16x16 multiplier between NREQ requesters.
//  clk_i / async_rst_i        : clock, async active-low reset
//  req_i, lock_i, sel_i       : per-requester request, lock hint, signed select
//  opd0_i, opd1_i             : packed operands, requester k at [16k+15:16k]
//  gnt_o                      : combinational one-hot grant
//  res_o, res_vld_o           : product and one-hot strobe, MUL_LAT after accept
//  arb2dsp_mul_*              : registered operands toward the DSP
//  dsp2arb_mul_res_i          : combinational product back from the DSP
module n1_dsp_mul_arb
  import n1_dsp_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ-1:0]       lock_i,
  input  logic [NREQ-1:0]       sel_i,
  input  logic [NREQ*OPD_W-1:0] opd0_i,
  input  logic [NREQ*OPD_W-1:0] opd1_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [RES_W-1:0]      res_o,
  output logic [NREQ-1:0]       res_vld_o,
  output logic                  arb2dsp_mul_sel_o,
  output logic [OPD_W-1:0]      arb2dsp_mul_opd0_o,
  output logic [OPD_W-1:0]      arb2dsp_mul_opd1_o,
  input  logic [RES_W-1:0]      dsp2arb_mul_res_i
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned STG   = MUL_LAT - 1;

  logic [PTR_W-1:0] ptr_q;
  lock_st_e         state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] run_c;
  logic             lock_vld_c;

  logic             accept_c;
  logic [PTR_W-1:0] win_id_c;
  logic [OPD_W-1:0] win_opd0_c;
  logic [OPD_W-1:0] win_opd1_c;
  logic             win_sel_c;

  pipe_tag_t        tag_q [STG];
  logic [RES_W-1:0] res_q [STG];

  n1_rr_arb #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arb (
    .req        (req_i),
    .ptr        (ptr_q),
    .lock_owner (owner_q),
    .lock_vld   (lock_vld_c),
    .gnt        (gnt_o)
  );

  // Grant only ever goes to a requester, so any grant bit is an accept.
  assign accept_c = |gnt_o;

  // Winner index and operand mux.
  always_comb begin
    win_id_c   = '0;
    win_opd0_c = '0;
    win_opd1_c = '0;
    win_sel_c  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt_o[k]) begin
        win_id_c   = PTR_W'(k);
        win_opd0_c = opd0_i[k*OPD_W +: OPD_W];
        win_opd1_c = opd1_i[k*OPD_W +: OPD_W];
        win_sel_c  = sel_i[k];
      end
    end
  end

  // Operand stage and round-robin pointer; operands hold across idle cycles.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      ptr_q              <= '0;
      arb2dsp_mul_sel_o  <= 1'b0;
      arb2dsp_mul_opd0_o <= '0;
      arb2dsp_mul_opd1_o <= '0;
    end else if (accept_c) begin
      ptr_q              <= PTR_W'((32'(win_id_c) + 32'd1) % NREQ);
      arb2dsp_mul_sel_o  <= win_sel_c;
      arb2dsp_mul_opd0_o <= win_opd0_c;
      arb2dsp_mul_opd1_o <= win_opd1_c;
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      state_q <= ST_UNLOCKED;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lock FSM next state: owner dropping req releases at once; the
  // LOCK_MAX-th consecutive locked accept ends the run.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    run_c   = '0;
    if ((state_q == ST_LOCKED) && !req_i[owner_q]) begin
      state_d = ST_UNLOCKED;
      cnt_d   = '0;
    end
    if (accept_c) begin
      if (lock_i[win_id_c]) begin
        run_c = ((state_q == ST_LOCKED) && (owner_q == win_id_c)) ? cnt_q + CNT_W'(1) : CNT_W'(1);
        if (run_c >= CNT_W'(LOCK_MAX)) begin
          state_d = ST_UNLOCKED;
          cnt_d   = '0;
        end else begin
          state_d = ST_LOCKED;
          owner_d = win_id_c;
          cnt_d   = run_c;
        end
      end else begin
        state_d = ST_UNLOCKED;
        cnt_d   = '0;
      end
    end
  end

  // Lock FSM output.
  always_comb begin
    lock_vld_c = 1'b0;
    if (state_q == ST_LOCKED) begin
      lock_vld_c = 1'b1;
    end
  end

  // Tag/result pipeline: slot 0 sees the DSP product, last slot feeds the outputs.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      for (int unsigned i = 0; i < STG; i++) begin
        tag_q[i] <= '0;
        res_q[i] <= '0;
      end
      res_vld_o <= '0;
    end else begin
      tag_q[0] <= {accept_c, ID_W'(win_id_c)};
      for (int unsigned i = 1; i < STG; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      if (tag_q[0].vld) begin
        res_q[0] <= dsp2arb_mul_res_i;
      end
      for (int unsigned i = 1; i < STG; i++) begin
        if (tag_q[i].vld) begin
          res_q[i] <= res_q[i-1];
        end
      end
      res_vld_o <= tag_q[STG-1].vld ? NREQ'(id2onehot(tag_q[STG-1].id)) : '0;
    end
  end

  assign res_o = res_q[STG-1];

endmodule

// File: tb/tb_n1_dsp_mul_arb.sv
module tb_n1_dsp_mul_arb;

  localparam int unsigned NREQ     = 2;
  localparam int unsigned MUL_LAT  = 2;
  localparam int unsigned LOCK_MAX = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req, lock, sel;
  logic [NREQ*16-1:0]  opd0, opd1;
  logic [NREQ-1:0]     gnt_o, res_vld_o;
  logic [31:0]         res_o, dsp_res;
  logic                m_sel;
  logic [15:0]         m_opd0, m_opd1;

  always #5 clk = ~clk;

  n1_dsp_mul_arb #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .LOCK_MAX(LOCK_MAX)) dut (
    .clk_i              (clk),
    .async_rst_i        (rst_n),
    .req_i              (req),
    .lock_i             (lock),
    .sel_i              (sel),
    .opd0_i             (opd0),
    .opd1_i             (opd1),
    .gnt_o              (gnt_o),
    .res_o              (res_o),
    .res_vld_o          (res_vld_o),
    .arb2dsp_mul_sel_o  (m_sel),
    .arb2dsp_mul_opd0_o (m_opd0),
    .arb2dsp_mul_opd1_o (m_opd1),
    .dsp2arb_mul_res_i  (dsp_res)
  );

  function automatic logic [31:0] mul_ref(input logic s, input logic [15:0] a, input logic [15:0] b);
    int sa, sb;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return 32'(sa * sb);
    end
    return 32'(a) * 32'(b);
  endfunction

  // Stand-in for the DSP's combinational multiplier.
  assign dsp_res = mul_ref(m_sel, m_opd0, m_opd1);

  int n_err = 0;
  int n_chk = 0;

  // Reference model state.
  int          cyc;
  int          ptr_m, own_m, run_m;
  logic [31:0] last_res;
  logic [15:0] exp_a, exp_b;
  logic        exp_s;
  int          due_q[$];
  int          id_q[$];
  logic [31:0] prod_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ptr_m = 0; own_m = -1; run_m = 0;
    last_res = '0; exp_a = '0; exp_b = '0; exp_s = 1'b0;
    due_q.delete(); id_q.delete(); prod_q.delete();
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model, cross the edge.
  task automatic step(input logic [1:0] rq, input logic [1:0] lk, input logic [1:0] sl,
                      input logic [31:0] a, input logic [31:0] b);
    int          win;
    logic [31:0] exp_vld;
    logic [15:0] ak, bk;
    req = rq; lock = lk; sel = sl; opd0 = a; opd1 = b;
    #4;
    if (own_m >= 0 && !rq[own_m]) begin
      own_m = -1; run_m = 0;
    end
    win = -1;
    if (own_m >= 0) win = own_m;
    else begin
      for (int i = 0; i < NREQ; i++) begin
        int j;
        j = (ptr_m + i) % NREQ;
        if (win < 0 && rq[j]) win = j;
      end
    end
    check("gnt", 32'(gnt_o), (win >= 0) ? (32'd1 << win) : 32'd0);
    exp_vld = '0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      exp_vld  = 32'd1 << id_q[0];
      last_res = prod_q[0];
      void'(due_q.pop_front()); void'(id_q.pop_front()); void'(prod_q.pop_front());
    end
    check("res_vld", 32'(res_vld_o), exp_vld);
    check("res", res_o, last_res);
    check("mul_opd0", 32'(m_opd0), 32'(exp_a));
    check("mul_opd1", 32'(m_opd1), 32'(exp_b));
    check("mul_sel", 32'(m_sel), 32'(exp_s));
    if (win >= 0) begin
      ak = a[16*win +: 16];
      bk = b[16*win +: 16];
      exp_a = ak; exp_b = bk; exp_s = sl[win];
      due_q.push_back(cyc + MUL_LAT);
      id_q.push_back(win);
      prod_q.push_back(mul_ref(sl[win], ak, bk));
      ptr_m = (win + 1) % NREQ;
      if (lk[win]) begin
        run_m = (own_m == win) ? run_m + 1 : 1;
        if (run_m >= LOCK_MAX) begin
          own_m = -1; run_m = 0;
        end else own_m = win;
      end else begin
        own_m = -1; run_m = 0;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic check_reset_outputs();
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_res_vld", 32'(res_vld_o), 32'd0);
    check("rst_res", res_o, 32'd0);
    check("rst_opd0", 32'(m_opd0), 32'd0);
    check("rst_opd1", 32'(m_opd1), 32'd0);
    check("rst_sel", 32'(m_sel), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; sel = '0; opd0 = '0; opd1 = '0;
    model_reset();
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // Basic product through requester 0.
    step(2'b01, 2'b00, 2'b00, {16'd0, 16'd3}, {16'd0, 16'd5});
    step(2'b00, 2'b00, 2'b00, '0, '0);
    step(2'b00, 2'b00, 2'b00, '0, '0);
    step(2'b00, 2'b00, 2'b00, '0, '0);

    // Round-robin alternation.
    repeat (4) step(2'b11, 2'b00, 2'b00, {16'd7, 16'd9}, {16'd11, 16'd13});
    repeat (3) step(2'b00, 2'b00, 2'b00, '0, '0);

    // Signed vs unsigned on identical operands.
    step(2'b01, 2'b00, 2'b01, {16'd0, 16'hFFFF}, {16'd0, 16'd2});
    step(2'b01, 2'b00, 2'b00, {16'd0, 16'hFFFF}, {16'd0, 16'd2});
    step(2'b10, 2'b00, 2'b10, {16'h8000, 16'd0}, {16'h8000, 16'd0});
    repeat (3) step(2'b00, 2'b00, 2'b00, '0, '0);

    // Bounded lock: owner 0 four times, then requester 1, then 0 again.
    repeat (7) step(2'b11, 2'b01, 2'b00, {16'd21, 16'd17}, {16'd4, 16'd3});

    // Owner drops its request while locked.
    step(2'b00, 2'b00, 2'b00, '0, '0);
    step(2'b11, 2'b01, 2'b00, {16'd5, 16'd6}, {16'd7, 16'd8});
    step(2'b10, 2'b00, 2'b00, {16'd5, 16'd6}, {16'd7, 16'd8});
    repeat (3) step(2'b00, 2'b00, 2'b00, '0, '0);

    // Randomized traffic, locks biased on.
    for (int n = 0; n < 400; n++) begin
      logic [1:0] rq, lk;
      rq = 2'($urandom);
      lk = ($urandom_range(0, 3) != 0) ? 2'($urandom) : 2'b00;
      step(rq, lk, 2'($urandom), $urandom, $urandom);
    end
    repeat (4) step(2'b00, 2'b00, 2'b00, '0, '0);

    // Reset with an op in flight.
    step(2'b01, 2'b00, 2'b01, {16'd0, 16'h1234}, {16'd0, 16'h0042});
    req = '0; lock = '0;
    rst_n = 1'b0;
    #4;
    check_reset_outputs();
    model_reset();
    @(posedge clk); #1;
    cyc++;
    rst_n = 1'b1;
    repeat (4) step(2'b00, 2'b00, 2'b00, '0, '0);
    step(2'b10, 2'b00, 2'b00, {16'd100, 16'd0}, {16'd3, 16'd0});
    repeat (3) step(2'b00, 2'b00, 2'b00, '0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
